hex_page_ctrl: RTL and testbench

Parametrised seven-segment display controller driving `DIGITS` hex nibbles from one of `NCH` operand channels plus a write-data field. Successor to the fixed two-mode operand/data selector. Adds:
- page selection, manual or auto-rotating;
- an edge-triggered write-capture with timed hold;
- per-digit enables.

It sits between the datapath register file / write-back stage and the hex-digit decoder array.

---
 rtl/hex_page_ctrl.sv | 133 +++++++++++++
 tb/tb_hex_page_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hex_page_ctrl.sv
// Paged seven-segment controller: operand channel on the left field, held write-back capture on the right.
// Define HEX_PAGE_LZB_EN to enable leading-zero blanking of the left field.
module hex_page_ctrl #(
  parameter int DIGITS = 8,
  parameter int DATA_W = 16,
  parameter int NCH    = 4,
  parameter int DWELL  = 50000000,
  parameter int HOLD   = 100000000
) (
  input  logic                                   clock,
  input  logic                                   reset_n,
  input  logic                                   esc_reg,
  input  logic [NCH*DATA_W-1:0]                  chan_data,
  input  logic [DATA_W-1:0]                      dado,
  input  logic                                   mode_auto,
  input  logic [((NCH > 2) ? $clog2(NCH) : 1)-1:0] page_sel,
  output logic                                   sinal,
  output logic [DIGITS-1:0]                      modo,
  output logic [4*DIGITS-1:0]                    display
);

  localparam int PW     = (NCH > 2) ? $clog2(NCH) : 1;
  localparam int DW     = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int HW     = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int LEFT_W = 2 * DIGITS;
  localparam int H      = DIGITS / 2;

  logic [PW-1:0]      page_q, page_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic               mode_prev_q, mode_prev_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [DATA_W-1:0]  shadow_q, shadow_d;
  logic               esc_prev_q, esc_prev_d;
  logic               sinal_q, sinal_d;
  logic [DIGITS-1:0]  modo_q, modo_d;
  logic [4*DIGITS-1:0] display_q, display_d;

  logic [DATA_W-1:0]  ch;
  logic [LEFT_W-1:0]  left, right;
  logic [H-1:0]       lmask;

  always_comb begin
    page_d      = page_q;
    dwell_d     = dwell_q;
    mode_prev_d = mode_auto;
    if (!mode_auto) begin
      dwell_d = '0;
      page_d  = (int'(page_sel) >= NCH) ? PW'(NCH - 1) : page_sel;
    end else if (!mode_prev_q) begin
      dwell_d = '0;
    end else if (dwell_q == DW'(DWELL - 1)) begin
      dwell_d = '0;
      page_d  = (page_q == PW'(NCH - 1)) ? '0 : page_q + PW'(1);
    end else begin
      dwell_d = dwell_q + DW'(1);
    end
  end

  always_comb begin
    esc_prev_d = esc_reg;
    shadow_d   = shadow_q;
    hold_d     = hold_q;
    sinal_d    = sinal_q;
    // A fresh edge wins over expiry, so a retrigger on the last held cycle extends the hold.
    if (esc_reg && !esc_prev_q) begin
      shadow_d = dado;
      hold_d   = HW'(HOLD - 1);
      sinal_d  = 1'b1;
    end else if (sinal_q) begin
      if (hold_q == '0) sinal_d = 1'b0;
      else              hold_d  = hold_q - HW'(1);
    end
  end

  always_comb begin
    ch = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (PW'(k) == page_d) ch = chan_data[k*DATA_W +: DATA_W];
    end
    left  = '0;
    right = '0;
    for (int unsigned b = 0; b < LEFT_W && b < DATA_W; b++) begin
      left[b]  = ch[b];
      right[b] = shadow_d[b];
    end
`ifdef HEX_PAGE_LZB_EN
    begin : lzb
      logic seen;
      int unsigned idx;
      seen = 1'b0;
      for (int unsigned j = 0; j < H; j++) begin
        idx = H - 1 - j;
        if (left[idx*4 +: 4] != '0 || idx == 0) seen = 1'b1;
        lmask[idx] = seen;
        if (!seen) left[idx*4 +: 4] = '0;
      end
    end
`else
    lmask = '1;
`endif
    display_d = {left, sinal_d ? right : {LEFT_W{1'b0}}};
    modo_d    = {lmask, {H{sinal_d}}};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      page_q      <= '0;
      dwell_q     <= '0;
      mode_prev_q <= 1'b0;
      hold_q      <= '0;
      shadow_q    <= '0;
      esc_prev_q  <= 1'b0;
      sinal_q     <= 1'b0;
      modo_q      <= '0;
      display_q   <= '0;
    end else begin
      page_q      <= page_d;
      dwell_q     <= dwell_d;
      mode_prev_q <= mode_prev_d;
      hold_q      <= hold_d;
      shadow_q    <= shadow_d;
      esc_prev_q  <= esc_prev_d;
      sinal_q     <= sinal_d;
      modo_q      <= modo_d;
      display_q   <= display_d;
    end
  end

  assign sinal   = sinal_q;
  assign modo    = modo_q;
  assign display = display_q;

endmodule

// File: tb/tb_hex_page_ctrl.sv
// Directed bench for hex_page_ctrl with DIGITS=8, DATA_W=16, NCH=4, DWELL=4, HOLD=3.
module tb_hex_page_ctrl;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        esc_reg;
  logic [63:0] chan_data;
  logic [15:0] dado;
  logic        mode_auto;
  logic [1:0]  page_sel;
  logic        sinal;
  logic [7:0]  modo;
  logic [31:0] display;

  int checks = 0;
  int errors = 0;

`ifdef HEX_PAGE_LZB_EN
  localparam logic [3:0] LM = 4'b0011;
`else
  localparam logic [3:0] LM = 4'b1111;
`endif

  hex_page_ctrl #(.DIGITS(8), .DATA_W(16), .NCH(4), .DWELL(4), .HOLD(3)) dut (
    .clock(clock), .reset_n(reset_n), .esc_reg(esc_reg), .chan_data(chan_data),
    .dado(dado), .mode_auto(mode_auto), .page_sel(page_sel),
    .sinal(sinal), .modo(modo), .display(display)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    esc_reg   = 1'($urandom);
    chan_data = {$urandom, $urandom};
    dado      = 16'($urandom);
    mode_auto = 1'($urandom);
    page_sel  = 2'($urandom);
    step();
    step();
    check("rst_display", display, 32'h0);
    check("rst_modo", {24'h0, modo}, 32'h0);
    check("rst_sinal", {31'h0, sinal}, 32'h0);

    chan_data = {16'h0044, 16'h0033, 16'h0022, 16'h0011};
    esc_reg = 1'b0; mode_auto = 1'b0; page_sel = 2'd0; dado = 16'h0;
    reset_n = 1'b1;
    step();
    check("post_rst_modo", {24'h0, modo}, {24'h0, LM, 4'h0});
    check("post_rst_display", display, 32'h0011_0000);

    page_sel = 2'd2; step();
    check("manual_p2", {16'h0, display[31:16]}, 32'h0033);
    page_sel = 2'd3; step();
    check("manual_p3", {16'h0, display[31:16]}, 32'h0044);

    // page 3 persists through the enabling edge, then 0,1,2,3 each for 4 cycles
    mode_auto = 1'b1;
    for (int i = 0; i < 17; i++) begin
      logic [15:0] exp_pg;
      step();
      exp_pg = (i < 4) ? 16'd3 : 16'((i - 4) / 4 % 4);
      check($sformatf("auto_%0d", i), {16'h0, display[31:16]}, 32'(16'h0011 * (exp_pg + 16'd1)));
    end

    mode_auto = 1'b0; page_sel = 2'd0; step();
    check("manual_back_p0", {16'h0, display[31:16]}, 32'h0011);

    dado = 16'hBEEF; esc_reg = 1'b1; step();
    check("cap_sinal_0", {31'h0, sinal}, 32'h1);
    check("cap_display_0", display, 32'h0011_BEEF);
    check("cap_modo_0", {24'h0, modo}, {24'h0, LM, 4'hF});
    esc_reg = 1'b0; dado = 16'h5555;
    for (int i = 1; i < 3; i++) begin
      step();
      check($sformatf("cap_sinal_%0d", i), {31'h0, sinal}, 32'h1);
      check($sformatf("cap_display_%0d", i), display, 32'h0011_BEEF);
    end
    step();
    check("cap_end_sinal", {31'h0, sinal}, 32'h0);
    check("cap_end_modo", {24'h0, modo}, {24'h0, LM, 4'h0});
    check("cap_end_display", display, 32'h0011_0000);

    dado = 16'h1111; esc_reg = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("held_%0d", i), {31'h0, sinal}, (i < 3) ? 32'h1 : 32'h0);
    end
    esc_reg = 1'b0; step();
    check("held_release", {31'h0, sinal}, 32'h0);

    dado = 16'hBEEF; esc_reg = 1'b1; step();
    check("retrig_first", display, 32'h0011_BEEF);
    esc_reg = 1'b0; step();
    check("retrig_gap", {31'h0, sinal}, 32'h1);
    dado = 16'h1234; esc_reg = 1'b1; step();
    check("retrig_edge", display, 32'h0011_1234);
    esc_reg = 1'b0;
    for (int i = 1; i < 3; i++) begin
      step();
      check($sformatf("retrig_sinal_%0d", i), {31'h0, sinal}, 32'h1);
      check($sformatf("retrig_right_%0d", i), {16'h0, display[15:0]}, 32'h1234);
    end
    step();
    check("retrig_end", {31'h0, sinal}, 32'h0);

    chan_data[15:0] = 16'h00A0; step();
`ifdef HEX_PAGE_LZB_EN
    check("lzb_00a0", {28'h0, modo[7:4]}, 32'h3);
`else
    check("lzb_00a0", {28'h0, modo[7:4]}, 32'hF);
`endif
    check("lzb_00a0_val", {16'h0, display[31:16]}, 32'h00A0);
    chan_data[15:0] = 16'h0000; step();
`ifdef HEX_PAGE_LZB_EN
    check("lzb_zero", {28'h0, modo[7:4]}, 32'h1);
`else
    check("lzb_zero", {28'h0, modo[7:4]}, 32'hF);
`endif
    check("lzb_zero_val", {16'h0, display[31:16]}, 32'h0);

    esc_reg = 1'b1; dado = 16'hCAFE; step();
    check("mid_hold_on", {31'h0, sinal}, 32'h1);
    esc_reg = 1'b0; reset_n = 1'b0; step();
    check("mid_hold_rst_sinal", {31'h0, sinal}, 32'h0);
    check("mid_hold_rst_display", display, 32'h0);
    reset_n = 1'b1; step();
    check("after_rst_sinal", {31'h0, sinal}, 32'h0);
    check("after_rst_right", {16'h0, display[15:0]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
